// File: rtl/bnn_pkg.sv
// Shared types, defaults and elaboration helpers for the sequential BNN layer.
// Imported by the top and the popcount sub-module.
package bnn_pkg;

    localparam int BNN_IN_W_DEF        = 32'sd8;
    localparam int BNN_NUM_NEURONS_DEF = 32'sd8;
    localparam int BNN_LOAD_W_DEF      = 32'sd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } bnn_state_e;

    function automatic int bnn_clog2(input int value);
        int res;
        int rem;
        res = 32'sd0;
        rem = value - 32'sd1;
        while (rem > 32'sd0) begin
            res = res + 32'sd1;
            rem = rem >>> 1;
        end
        return res;
    endfunction

    // Majority-plus-one of the input bits: an untrained neuron fires only on a clear match.
    function automatic int bnn_default_th(input int in_w);
        return (in_w / 32'sd2) + 32'sd1;
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational XNOR-popcount: number of bit positions where x and w agree.
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int IN_W  = BNN_IN_W_DEF,
    parameter int CNT_W = bnn_clog2(BNN_IN_W_DEF + 32'sd1)
) (
    input  logic [IN_W-1:0]  x_i,
    input  logic [IN_W-1:0]  w_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [IN_W-1:0]  match_s;
    logic [CNT_W-1:0] sum_s;

    assign match_s = ~(x_i ^ w_i);

    // Sum the agreement bits.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < IN_W; i++) begin
            sum_s = sum_s + CNT_W'(match_s[i]);
        end
    end

    assign cnt_o = sum_s;

endmodule

// File: rtl/bnn_seq_layer.sv
// Time-multiplexed binary neural network layer: one XNOR-popcount-threshold
// neuron per cycle, with runtime-loadable weights and thresholds.
module bnn_seq_layer
    import bnn_pkg::*;
#(
    parameter int IN_W        = BNN_IN_W_DEF,
    parameter int NUM_NEURONS = BNN_NUM_NEURONS_DEF,
    parameter int LOAD_W      = BNN_LOAD_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   load_en,
    input  logic                   load_sel,
    input  logic                   load_clr,
    input  logic [LOAD_W-1:0]      load_data,
    output logic                   load_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] out_data,
    output logic                   busy
);

    localparam int CNT_W  = bnn_clog2(IN_W + 32'sd1);
    localparam int BEATS  = IN_W / LOAD_W;
    localparam int IDX_W  = (NUM_NEURONS > 32'sd1) ? bnn_clog2(NUM_NEURONS) : 32'sd1;
    localparam int WB_W   = (BEATS > 32'sd1) ? bnn_clog2(BEATS) : 32'sd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 32'sd1);
    localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(BEATS - 32'sd1);
    localparam logic [CNT_W-1:0] TH_RST   = CNT_W'(bnn_default_th(IN_W));

    generate
        if ((IN_W % LOAD_W) != 32'sd0) begin : g_bad_load_w
            $error("bnn_seq_layer: IN_W must be a multiple of LOAD_W");
        end
        if (CNT_W > LOAD_W) begin : g_bad_cnt_w
            $error("bnn_seq_layer: LOAD_W must be at least CNT_W");
        end
    endgenerate

    bnn_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IN_W-1:0]         x_q, x_d;
    logic [NUM_NEURONS-1:0]  out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic [IDX_W-1:0]        wn_q, wn_d;
    logic [WB_W-1:0]         wb_q, wb_d;
    logic [IDX_W-1:0]        tn_q, tn_d;
    logic [IN_W-1:0]         w_q  [NUM_NEURONS];
    logic [CNT_W-1:0]        th_q [NUM_NEURONS];
    logic                    w_we_s;
    logic                    th_we_s;
    logic                    idle_s;
    logic [CNT_W-1:0]        pop_cnt_s;
    logic                    fire_s;

    assign idle_s     = (state_q == ST_IDLE);
    assign in_ready   = idle_s & ~load_en;
    assign load_ready = idle_s;
    assign busy       = ~idle_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_q;

    bnn_popcount #(
        .IN_W  (IN_W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .x_i   (x_q),
        .w_i   (w_q[idx_q]),
        .cnt_o (pop_cnt_s)
    );

    assign fire_s = (pop_cnt_s >= th_q[idx_q]);

    // Next-state, datapath and load-pointer decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        wn_d        = wn_q;
        wb_d        = wb_q;
        tn_d        = tn_q;
        w_we_s      = 1'b0;
        th_we_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    // A load beat always wins over a same-cycle input vector.
                    if (load_clr) begin
                        w_we_s  = 1'b0;
                        th_we_s = 1'b0;
                    end else if (load_sel == 1'b0) begin
                        w_we_s = 1'b1;
                        if (wb_q == LAST_WB) begin
                            wb_d = '0;
                            wn_d = (wn_q == LAST_IDX) ? '0 : (wn_q + IDX_W'(1));
                        end else begin
                            wb_d = wb_q + WB_W'(1);
                        end
                    end else begin
                        th_we_s = 1'b1;
                        tn_d    = (tn_q == LAST_IDX) ? '0 : (tn_q + IDX_W'(1));
                    end
                end else if (in_valid) begin
                    x_d     = in_data;
                    out_d   = '0;
                    idx_d   = '0;
                    state_d = ST_COMPUTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                out_d[idx_q] = fire_s;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        if (load_clr) begin
            wn_d = '0;
            wb_d = '0;
            tn_d = '0;
        end else begin
            wn_d = wn_d;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wn_q        <= '0;
            wb_q        <= '0;
            tn_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wn_q        <= wn_d;
            wb_q        <= wb_d;
            tn_q        <= tn_d;
        end
    end

    // Weight and threshold storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                w_q[n]  <= '0;
                th_q[n] <= TH_RST;
            end
        end else begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (w_we_s && (wn_q == IDX_W'(n))) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (wb_q == WB_W'(b)) begin
                            w_q[n][b*LOAD_W +: LOAD_W] <= load_data;
                        end
                    end
                end
                if (th_we_s && (tn_q == IDX_W'(n))) begin
                    th_q[n] <= load_data[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_seq_layer.sv
// Self-checking bench for bnn_seq_layer at default parameters, using a
// behavioural model of weights, thresholds and load pointers.
module tb_bnn_seq_layer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       load_en = 1'b0;
    logic       load_sel = 1'b0;
    logic       load_clr = 1'b0;
    logic [3:0] load_data = 4'h0;
    logic       load_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] model_w  [8];
    int         model_th [8];
    int         mwn, mwb, mtn;

    bnn_seq_layer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .load_en    (load_en),
        .load_sel   (load_sel),
        .load_clr   (load_clr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int n = 0; n < 8; n++) begin
            model_w[n]  = 8'h00;
            model_th[n] = 5;
        end
        mwn = 0; mwb = 0; mtn = 0;
    endtask

    function automatic logic [7:0] model_eval(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] agree;
        for (int n = 0; n < 8; n++) begin
            agree = ~(x ^ model_w[n]);
            r[n] = ($countones(agree) >= model_th[n]);
        end
        return r;
    endfunction

    // One accepted load beat (or clear) in IDLE; the model follows the loading rules.
    task automatic load_beat(input logic sel, input logic [3:0] d, input logic clr);
        load_en = 1'b1; load_sel = sel; load_data = d; load_clr = clr;
        #1;
        compared++;
        if (load_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL load_ready_idle: got %b expected 1", load_ready);
        end
        @(posedge clk); #1;
        load_en = 1'b0; load_clr = 1'b0;
        if (clr) begin
            mwn = 0; mwb = 0; mtn = 0;
        end else if (!sel) begin
            model_w[mwn][mwb*4 +: 4] = d;
            mwb = mwb + 1;
            if (mwb == 2) begin
                mwb = 0;
                mwn = (mwn + 1) % 8;
            end
        end else begin
            model_th[mtn] = int'(d);
            mtn = (mtn + 1) % 8;
        end
    endtask

    task automatic clear_ptrs();
        load_clr = 1'b1;
        @(posedge clk); #1;
        load_clr = 1'b0;
        mwn = 0; mwb = 0; mtn = 0;
    endtask

    // Present one vector, check latency, result, backpressure and busy duration.
    task automatic run_vector(input logic [7:0] x, input int hold);
        logic [7:0] exp;
        logic [7:0] snap;
        int lat;
        int busy_cnt;
        exp = model_eval(x);
        in_valid = 1'b1; in_data = x; out_ready = (hold == 0);
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL in_ready_idle: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
        end
        compared++;
        if (lat != 8) begin
            mismatched++;
            $display("FAIL latency: got %0d cycles expected 8", lat);
        end
        compared++;
        if (out_data !== exp) begin
            mismatched++;
            $display("FAIL out_data x=%h: got %h expected %h", x, out_data, exp);
        end
        snap = out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) busy_cnt++;
            compared++;
            if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL backpressure: got valid=%b data=%h in_ready=%b busy=%b expected 1 %h 0 1",
                         out_valid, out_data, in_ready, busy, snap);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL release_idle: got valid=%b busy=%b in_ready=%b expected 0 0 1",
                     out_valid, busy, in_ready);
        end
        compared++;
        if (busy_cnt != 9 + hold) begin
            mismatched++;
            $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, 9 + hold);
        end
    endtask

    task automatic test_reset();
        #12;
        compared++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1 || load_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_state: got valid=%b data=%h busy=%b in_ready=%b load_ready=%b expected 0 00 0 1 1",
                     out_valid, out_data, busy, in_ready, load_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_defaults();
        run_vector(8'h00, 0);
        run_vector(8'hFF, 0);
    endtask

    task automatic test_weight_load();
        clear_ptrs();
        load_beat(1'b0, 4'h0, 1'b0);
        load_beat(1'b0, 4'hF, 1'b0);
        run_vector(8'hF0, 0);
        run_vector(8'h0F, 0);
    endtask

    task automatic test_threshold_bounds();
        clear_ptrs();
        load_beat(1'b1, 4'h0, 1'b0);
        load_beat(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) run_vector(8'($urandom), 0);
        run_vector(8'hFF, 0);
        run_vector(8'h00, 0);
    endtask

    task automatic test_backpressure();
        run_vector(8'h5A, 10);
    endtask

    task automatic test_load_during_compute();
        logic [7:0] x;
        logic [7:0] exp;
        int c;
        x = 8'($urandom);
        exp = model_eval(x);
        in_valid = 1'b1; in_data = x; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_sel = i[0]; load_data = 4'hA;
            #1;
            compared++;
            if (load_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL load_ready_busy: got %b expected 0", load_ready);
            end
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        c = 0;
        while (out_valid !== 1'b1 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        compared++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            mismatched++;
            $display("FAIL compute_with_loads: got valid=%b data=%h expected 1 %h", out_valid, out_data, exp);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_vector(8'($urandom), 0);
    endtask

    task automatic test_load_wins();
        load_en = 1'b1; load_sel = 1'b0; load_data = 4'h3;
        in_valid = 1'b1; in_data = 8'hC3;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL load_wins_in_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        load_en = 1'b0; in_valid = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL load_wins_not_accepted: got busy=%b expected 0", busy);
        end
        model_w[mwn][mwb*4 +: 4] = 4'h3;
        mwb = mwb + 1;
        if (mwb == 2) begin
            mwb = 0;
            mwn = (mwn + 1) % 8;
        end
        run_vector(8'hC3, 0);
    endtask

    task automatic test_wrap_clr();
        clear_ptrs();
        for (int i = 0; i < 16; i++) load_beat(1'b0, 4'($urandom), 1'b0);
        load_beat(1'b0, 4'h9, 1'b0);
        for (int i = 0; i < 3; i++) run_vector(8'($urandom), 0);
        load_beat(1'b0, 4'hF, 1'b1);
        load_beat(1'b0, 4'h6, 1'b0);
        run_vector(8'h06, 0);
        run_vector(8'($urandom), 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            if (it[0] == 1'b0) clear_ptrs();
            for (int i = 0; i < 16; i++) load_beat(1'b0, 4'($urandom), 1'b0);
            for (int i = 0; i < 8; i++) load_beat(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            for (int v = 0; v < 3; v++) run_vector(8'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || load_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset: got valid=%b busy=%b data=%h load_ready=%b expected 0 0 00 1",
                     out_valid, busy, out_data, load_ready);
        end
        #2;
        reset = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        run_vector(8'h00, 0);
        run_vector(8'($urandom), 1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_weight_load();
        test_threshold_bounds();
        test_backpressure();
        test_load_during_compute();
        test_load_wins();
        test_wrap_clr();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
